// File: rtl/free_ptr_arbiter.sv
// Round-robin sequencer for the shared-cache free pointer FIFO: one allocation
// pop and one release push per cycle, plus free-cell count and watermark.
module free_ptr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PTR_BIT   = 8,
  parameter int unsigned LOW_WM    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_PORTS-1:0]         alloc_req,
  output logic [NUM_PORTS-1:0]         alloc_gnt,
  output logic [PTR_BIT-1:0]           alloc_ptr,
  input  logic [NUM_PORTS-1:0]         rel_req,
  input  logic [NUM_PORTS*PTR_BIT-1:0] rel_ptr,
  output logic [NUM_PORTS-1:0]         rel_ack,
  output logic                         fifo_rd,
  output logic                         fifo_wr,
  output logic [PTR_BIT-1:0]           fifo_w_data,
  input  logic [PTR_BIT-1:0]           fifo_r_data,
  input  logic                         fifo_empty,
  input  logic                         fifo_full,
  output logic [PTR_BIT:0]             free_cnt,
  output logic                         free_low,
  output logic                         err_rel_full
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = PTR_BIT + 1;
  localparam int unsigned POOL  = 1 << PTR_BIT;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(POOL);
  localparam logic [CNT_W-1:0] CNT_LOW  = CNT_W'(LOW_WM);

  // First requester at or after rr, searching upward modulo NUM_PORTS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [IDX_W-1:0] rr);
    logic [IDX_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = rr;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (32'(rr) + 32'(i)) % NUM_PORTS;
      if (!found && req[IDX_W'(idx)]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] win);
    return IDX_W'((32'(win) + 32'd1) % NUM_PORTS);
  endfunction

  logic [IDX_W-1:0] alloc_rr, rel_rr;
  logic [IDX_W-1:0] alloc_win, rel_win;
  logic             alloc_ok, rel_ok;
  logic [CNT_W-1:0] cnt_nxt;

  // Grant/ack decode; everything is forced low while reset is asserted.
  always_comb begin
    alloc_gnt   = '0;
    rel_ack     = '0;
    alloc_ptr   = '0;
    fifo_w_data = '0;
    alloc_win   = rr_pick(alloc_req, alloc_rr);
    rel_win     = rr_pick(rel_req, rel_rr);
    alloc_ok    = ~rst & en & ~fifo_empty & (|alloc_req);
    rel_ok      = ~rst & ~fifo_full & (|rel_req);
    if (alloc_ok) begin
      alloc_gnt[alloc_win] = 1'b1;
      alloc_ptr            = fifo_r_data;
    end
    if (rel_ok) begin
      rel_ack[rel_win] = 1'b1;
      fifo_w_data      = rel_ptr[32'(rel_win)*PTR_BIT +: PTR_BIT];
    end
    fifo_rd = alloc_ok;
    fifo_wr = rel_ok;
    cnt_nxt = free_cnt;
    if (rel_ok && !alloc_ok && free_cnt != CNT_FULL) begin
      cnt_nxt = free_cnt + CNT_W'(1);
    end else if (alloc_ok && !rel_ok && free_cnt != '0) begin
      cnt_nxt = free_cnt - CNT_W'(1);
    end
  end

  // Round-robin pointers, free count, watermark and sticky duplicate-release flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_rr     <= '0;
      rel_rr       <= '0;
      free_cnt     <= CNT_FULL;
      free_low     <= 1'b0;
      err_rel_full <= 1'b0;
    end else begin
      if (alloc_ok) alloc_rr <= next_rr(alloc_win);
      if (rel_ok)   rel_rr   <= next_rr(rel_win);
      if (fifo_full && (|rel_req)) err_rel_full <= 1'b1;
      free_cnt <= cnt_nxt;
      free_low <= (cnt_nxt <= CNT_LOW);
    end
  end

endmodule

// File: tb/tb_free_ptr_arbiter.sv
// Scoreboard bench for free_ptr_arbiter: queue-based reference model of the
// pointer pool and round-robin rules, with a behavioural free pointer FIFO.
module tb_free_ptr_arbiter;

  localparam int NP   = 4;
  localparam int PB   = 3;
  localparam int LW   = 2;
  localparam int POOL = 8;
  localparam int CW   = PB + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic [NP-1:0]     alloc_req = '0;
  logic [NP-1:0]     rel_req = '0;
  logic [NP*PB-1:0]  rel_ptr = '0;
  logic [NP-1:0]     alloc_gnt, rel_ack;
  logic [PB-1:0]     alloc_ptr, fifo_w_data;
  logic [PB-1:0]     fifo_r_data = '0;
  logic              fifo_empty = 1'b0, fifo_full = 1'b1;
  logic              fifo_rd, fifo_wr;
  logic [PB:0]       free_cnt;
  logic              free_low, err_rel_full;

  free_ptr_arbiter #(.NUM_PORTS(NP), .PTR_BIT(PB), .LOW_WM(LW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_ptr(alloc_ptr),
    .rel_req(rel_req), .rel_ptr(rel_ptr), .rel_ack(rel_ack),
    .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data),
    .fifo_r_data(fifo_r_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .free_cnt(free_cnt), .free_low(free_low), .err_rel_full(err_rel_full)
  );

  always #5 clk = ~clk;

  // Behavioural free pointer FIFO, refilled with 0..POOL-1 on reset.
  logic [PB-1:0] fq[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      for (int i = 0; i < POOL; i++) fq.push_back(PB'(i));
    end else begin
      if (fifo_rd && fq.size() > 0) void'(fq.pop_front());
      if (fifo_wr && fq.size() < POOL) fq.push_back(fifo_w_data);
    end
    fifo_empty  <= (fq.size() == 0);
    fifo_full   <= (fq.size() == POOL);
    fifo_r_data <= (fq.size() > 0) ? fq[0] : '0;
  end

  typedef struct { int cyc; int port; logic [PB-1:0] ptr; } exp_t;
  typedef struct { int cyc; logic [CW-1:0] cnt; logic low; logic err; } st_t;
  exp_t aq[$], rq[$];
  st_t  sq[$];

  int total = 0, bad = 0, cyc = 0;
  logic mon_on = 1'b0;

  // Reference model state.
  logic [PB-1:0] mq[$];
  int   m_arr, m_rrr, m_cnt;
  logic m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp_v);
    end
  endtask

  function automatic int rr_pick(input logic [NP-1:0] req, input int start);
    for (int i = 0; i < NP; i++)
      if (req[(start + i) % NP]) return (start + i) % NP;
    return -1;
  endfunction

  function automatic logic [NP*PB-1:0] pk(input int port, input int val);
    logic [NP*PB-1:0] v;
    v = '0;
    v[port*PB +: PB] = PB'(val);
    return v;
  endfunction

  // One cycle of stimulus; the model predicts the cycle's response and advances.
  task automatic drive(input logic e, input logic [NP-1:0] ar, input logic [NP-1:0] rb,
                       input logic [NP*PB-1:0] rp, output int aw, output int rw);
    exp_t a, r;
    st_t  s;
    @(posedge clk); #1;
    en = e; alloc_req = ar; rel_req = rb; rel_ptr = rp;
    cyc++;
    s.cyc = cyc; s.cnt = CW'(m_cnt); s.low = (m_cnt <= LW); s.err = m_err;
    sq.push_back(s);
    aw = -1; rw = -1;
    if (e && mq.size() > 0 && ar != 0) begin
      aw = rr_pick(ar, m_arr);
      a.cyc = cyc; a.port = aw; a.ptr = mq[0];
      aq.push_back(a);
    end
    if (rb != 0) begin
      if (mq.size() < POOL) begin
        rw = rr_pick(rb, m_rrr);
        r.cyc = cyc; r.port = rw; r.ptr = rp[rw*PB +: PB];
        rq.push_back(r);
      end else begin
        m_err = 1'b1;
      end
    end
    if (aw >= 0) begin
      void'(mq.pop_front());
      m_arr = (aw + 1) % NP;
      m_cnt--;
    end
    if (rw >= 0) begin
      mq.push_back(r.ptr);
      m_rrr = (rw + 1) % NP;
      m_cnt++;
    end
    mon_on = 1'b1;
  endtask

  // Asserts reset with the current inputs still applied, checks the reset state.
  task automatic do_reset();
    @(posedge clk); #1;
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_alloc_gnt", 32'(alloc_gnt), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_rel_ack", 32'(rel_ack), 32'd0);
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_free_cnt", 32'(free_cnt), 32'(POOL));
    chk("rst_free_low", 32'(free_low), 32'd0);
    chk("rst_err", 32'(err_rel_full), 32'd0);
    chk("queue_leftover", 32'(aq.size() + rq.size() + sq.size()), 32'd0);
    aq.delete(); rq.delete(); sq.delete();
    mq.delete();
    for (int i = 0; i < POOL; i++) mq.push_back(PB'(i));
    m_arr = 0; m_rrr = 0; m_cnt = POOL; m_err = 1'b0;
    @(posedge clk); #1;
    alloc_req = '0; rel_req = '0; en = 1'b0;
    rst = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or ack.
  exp_t ma, mr;
  st_t  ms;
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (sq.size() == 0) chk("status_queue_empty", 32'd1, 32'd0);
      else begin
        ms = sq.pop_front();
        chk("free_cnt", 32'(free_cnt), 32'(ms.cnt));
        chk("free_low", 32'(free_low), 32'(ms.low));
        chk("err_rel_full", 32'(err_rel_full), 32'(ms.err));
      end
      if (alloc_gnt != 0 || fifo_rd) begin
        if (aq.size() == 0) chk("alloc_unexpected", 32'(alloc_gnt), 32'd0);
        else begin
          ma = aq.pop_front();
          chk("alloc_cycle", 32'(cyc), 32'(ma.cyc));
          chk("alloc_gnt", 32'(alloc_gnt), 32'd1 << ma.port);
          chk("alloc_ptr", 32'(alloc_ptr), 32'(ma.ptr));
          chk("fifo_rd", 32'(fifo_rd), 32'd1);
        end
      end else if (aq.size() > 0 && aq[0].cyc == cyc) begin
        ma = aq.pop_front();
        chk("alloc_missing", 32'(alloc_gnt), 32'd1 << ma.port);
      end
      if (rel_ack != 0 || fifo_wr) begin
        if (rq.size() == 0) chk("rel_unexpected", 32'(rel_ack), 32'd0);
        else begin
          mr = rq.pop_front();
          chk("rel_cycle", 32'(cyc), 32'(mr.cyc));
          chk("rel_ack", 32'(rel_ack), 32'd1 << mr.port);
          chk("fifo_w_data", 32'(fifo_w_data), 32'(mr.ptr));
          chk("fifo_wr", 32'(fifo_wr), 32'd1);
        end
      end else if (rq.size() > 0 && rq[0].cyc == cyc) begin
        mr = rq.pop_front();
        chk("rel_missing", 32'(rel_ack), 32'd1 << mr.port);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int aw, rw;
    logic [NP-1:0]    ar, rb;
    logic [NP*PB-1:0] rp;

    do_reset();
    // Round-robin over all four, then simultaneous pop+push and watermark.
    repeat (4) drive(1'b1, 4'b1111, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0010, 4'b1000, pk(3, 6), aw, rw);
    drive(1'b1, 4'b0001, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0001, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0000, 4'b0001, pk(0, 1), aw, rw);
    drive(1'b1, 4'b0000, 4'b0000, '0, aw, rw);

    // Empty pool: no bypass, released pointer granted the next cycle.
    do_reset();
    repeat (8) drive(1'b1, 4'b1111, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0001, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0001, 4'b0100, pk(2, 5), aw, rw);
    drive(1'b1, 4'b0001, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0000, 4'b0000, '0, aw, rw);

    // Duplicate release into a full pool: sticky error.
    do_reset();
    drive(1'b1, 4'b0000, 4'b0001, pk(0, 3), aw, rw);
    repeat (3) drive(1'b1, 4'b0000, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0001, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0000, 4'b0010, pk(1, 2), aw, rw);
    drive(1'b1, 4'b0000, 4'b0000, '0, aw, rw);

    // Enable gating: pointer holds while en is low.
    do_reset();
    repeat (2) drive(1'b1, 4'b1111, 4'b0000, '0, aw, rw);
    repeat (5) drive(1'b0, 4'b1111, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b1111, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0000, 4'b0000, '0, aw, rw);

    // Reset in the middle of a burst, requests still held.
    do_reset();
    repeat (3) drive(1'b1, 4'b1111, 4'b0000, '0, aw, rw);
    do_reset();
    drive(1'b1, 4'b1111, 4'b0000, '0, aw, rw);
    drive(1'b1, 4'b0000, 4'b0000, '0, aw, rw);

    // Randomized traffic: requests held until granted, then dropped or renewed.
    do_reset();
    ar = '0; rb = '0; rp = '0;
    for (int n = 0; n < 800; n++) begin
      drive(($urandom_range(0, 9) != 0), ar, rb, rp, aw, rw);
      if (aw >= 0 && $urandom_range(0, 1) == 1) ar[aw] = 1'b0;
      ar |= NP'($urandom) & NP'($urandom);
      if (rw >= 0) begin
        rb[rw] = ($urandom_range(0, 1) == 1);
        rp[rw*PB +: PB] = PB'($urandom);
      end
      rb |= NP'($urandom) & NP'($urandom);
    end
    drive(1'b1, 4'b0000, 4'b0000, '0, aw, rw);
    @(posedge clk); #1;
    mon_on = 1'b0;
    chk("final_queue_leftover", 32'(aq.size() + rq.size() + sq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/free_ptr_arbiter.md
Name: free_ptr_arbiter

Overview:
- Sequences the shared-cache free pointer FIFO and shares it among NUM_PORTS input ports, which allocate cells, and NUM_PORTS output ports, which release cells.
- Arbitrates round-robin, at most one allocation pop and one release push per cycle.
- Drives the FIFO's rd, wr and w_data; tracks the free-cell count for watermark backpressure.
- Sits between the port write/read engines and the free pointer FIFO in the switching core.

Parameters:
NUM_PORTS, 4, number of allocate requesters and number of release requesters
PTR_BIT, 8, cell pointer width; pool depth is 2**PTR_BIT
LOW_WM, 4, free_low asserts when free_cnt <= LOW_WM

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  allocation enable; when low, no alloc grants are issued (releases still served)
alloc_req  in  NUM_PORTS  per-port allocate request, held until granted
alloc_gnt  out  NUM_PORTS  one-hot grant, combinational, same cycle as fifo_rd
alloc_ptr  out  PTR_BIT  granted pointer (= fifo_r_data), valid when |alloc_gnt
rel_req  in  NUM_PORTS  per-port release request, held until acked
rel_ptr  in  NUM_PORTS*PTR_BIT  packed release pointers; port k at bits [k*PTR_BIT +: PTR_BIT]
rel_ack  out  NUM_PORTS  one-hot release accept, combinational, same cycle as fifo_wr
fifo_rd  out  1  pop to free pointer FIFO
fifo_wr  out  1  push to free pointer FIFO
fifo_w_data  out  PTR_BIT  pushed pointer
fifo_r_data  in  PTR_BIT  FIFO head (combinational read)
fifo_empty  in  1  FIFO empty flag
fifo_full  in  1  FIFO full flag
free_cnt  out  PTR_BIT+1  registered count of free cells
free_low  out  1  registered, free_cnt <= LOW_WM
err_rel_full  out  1  sticky: release attempted while FIFO full

Behaviour:
- Reset (async, rst=1) values:
  - free_cnt = 2**PTR_BIT (pool starts full).
  - free_low = 0.
  - err_rel_full = 0.
  - Both round-robin pointers = port 0.
  - All combinational outputs low while rst is high.
- Allocation path:
  - alloc_ok = en & ~fifo_empty & |alloc_req.
  - Winner = first requesting port at or after alloc_rr, searching upward mod NUM_PORTS.
  - When alloc_ok: alloc_gnt[winner]=1, fifo_rd=1, alloc_ptr=fifo_r_data, all in the same cycle.
  - At the next edge: alloc_rr <= winner+1 mod NUM_PORTS.
  - A requester drops or renews its req after seeing its gnt; a held req is re-arbitrated in the next cycle.
- Release path:
  - rel_ok = ~fifo_full & |rel_req.
  - Winner chosen the same way using rel_rr.
  - When rel_ok: rel_ack[winner]=1, fifo_wr=1, fifo_w_data=rel_ptr[winner].
  - At the next edge: rel_rr <= winner+1 mod NUM_PORTS.
- The two arbiters are independent. Simultaneous pop+push in one cycle is allowed only when each is individually legal.
  - fifo_rd is never asserted while fifo_empty=1.
  - fifo_wr is never asserted while fifo_full=1, including when both are issued together.
  - There is no bypass: a pointer released while the FIFO is empty is not granted in the same cycle.
- |rel_req while fifo_full=1: no ack; err_rel_full <= 1, sticky until reset (this indicates a duplicate release).
- free_cnt update at each edge: +1 on push only, -1 on pop only, unchanged on both or neither. It never wraps; range 0..2**PTR_BIT.
- free_low is registered from the next value of free_cnt, so it updates on the same edge as free_cnt.
- Latency:
  - Grant/ack is 0 cycles from request when resources are available.
  - Worst-case wait for a persistently requesting port is NUM_PORTS-1 grant cycles.
- Deasserting en mid-stream blocks new grants immediately. The RR pointer holds until the next grant.

Test Plan (NUM_PORTS=4, PTR_BIT=3, LOW_WM=2):
- Reset, then alloc_req=4'b1111 held for 4 cycles -> alloc_gnt 0001,0010,0100,1000; alloc_ptr 0,1,2,3; free_cnt 8->4.
- Allocate all 8 pointers, then alloc_req=0001 -> no gnt, fifo_rd=0. Assert rel_req[2] with ptr 5 -> rel_ack=0100, fifo_w_data=5. Next cycle alloc_gnt=0001, alloc_ptr=5.
- With pool full after reset, rel_req=0001 with ptr 3 -> rel_ack=0, fifo_wr=0, err_rel_full=1 and remains 1 until rst.
- With free_cnt=4: alloc_req=0010 and rel_req=1000 in the same cycle -> gnt and ack both asserted; free_cnt stays 4.
- Allocate down to free_cnt=3 -> free_low=0. One more alloc -> free_cnt=2, free_low=1. Release one -> free_low=0.
- With en=0 and alloc_req=1111 -> no grants for 5 cycles. Raise en -> grant resumes at the port after the last winner.
- Assert rst mid-burst -> all outputs low immediately; free_cnt=8 and RR pointers at port 0 after release.
